// File: rtl/mem_xbar_n.sv
// N-target memory crossbar: decodes a word address to one target, forwards the
// request with a registered one-hot strobe and returns exactly one response.
module mem_xbar_n #(
   parameter int                      NUM_TGT   = 2,
   parameter int                      AW        = 30,
   parameter int                      DW        = 32,
   parameter logic [NUM_TGT*AW-1:0]   TGT_BASE  = '0,
   parameter logic [NUM_TGT*AW-1:0]   TGT_LIMIT = '0,
   parameter int                      TIMEOUT   = 255,
   parameter int                      ECW       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [AW-1:0]         i_addr,
   input  logic [DW-1:0]         i_data,
   input  logic                  i_wren,
   input  logic [DW/8-1:0]       i_mask,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DW-1:0]         o_rsp_data,
   output logic                  o_rsp_err,
   output logic [ECW-1:0]        o_err_cnt,
   output logic [NUM_TGT-1:0]    o_tgt_sel,
   output logic [AW-1:0]         o_tgt_addr,
   output logic [DW-1:0]         o_tgt_data,
   output logic                  o_tgt_wren,
   output logic [DW/8-1:0]       o_tgt_mask,
   input  logic [NUM_TGT-1:0]    i_tgt_ready,
   input  logic [NUM_TGT-1:0]    i_tgt_rsp_valid,
   input  logic [NUM_TGT*DW-1:0] i_tgt_rsp_data
);

   localparam int MW  = DW / 8;
   localparam int IW  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   state_e         state_q, state_d;
   logic [IW-1:0]  tgt_q, tgt_d;
   logic [AW-1:0]  off_q, off_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic           wren_q, wren_d;
   logic [MW-1:0]  mask_q, mask_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic           err_q, err_d;
   logic [ECW-1:0] ecnt_q, ecnt_d;
   logic [WDW-1:0] wd_q, wd_d;

   logic           hit;
   logic [IW-1:0]  hit_idx;
   logic [AW-1:0]  hit_off;
   logic           sel_rdy, sel_rv, wd_exp, set_err;
   logic [DW-1:0]  sel_rdata;

   // Scan from the top index down so the lowest matching region wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_off = '0;
      for (int k = NUM_TGT - 1; k >= 0; k--) begin
         if ((TGT_BASE[k*AW +: AW] <= i_addr) && (i_addr < TGT_LIMIT[k*AW +: AW])) begin
            hit     = 1'b1;
            hit_idx = IW'(k);
            hit_off = i_addr - TGT_BASE[k*AW +: AW];
         end
      end
   end

   assign sel_rdy   = i_tgt_ready[tgt_q];
   assign sel_rv    = i_tgt_rsp_valid[tgt_q];
   assign sel_rdata = i_tgt_rsp_data[tgt_q*DW +: DW];
   assign wd_exp    = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
         wd_q    <= wd_d;
      end
   end

   // Request fields are only observed in REQ, after they have been loaded.
   always_ff @(posedge clk) begin
      tgt_q   <= tgt_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      mask_q  <= mask_d;
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      wren_d  = wren_q;
      mask_d  = mask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wd_d    = wd_q;
      set_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               wdata_d = i_data;
               wren_d  = i_wren;
               mask_d  = i_mask;
               if (hit) begin
                  tgt_d   = hit_idx;
                  off_d   = hit_off;
                  wd_d    = '0;
                  state_d = S_REQ;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  set_err = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_REQ, S_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (sel_rv && (sel_rdy || (state_q == S_WAIT))) begin
               rdata_d = wren_q ? '0 : sel_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (wd_exp) begin
               rdata_d = '0;
               err_d   = 1'b1;
               set_err = 1'b1;
               state_d = S_RESP;
            end else if ((state_q == S_REQ) && sel_rdy) begin
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      ecnt_d = (set_err && (ecnt_q != '1)) ? ecnt_q + 1'b1 : ecnt_q;
   end

   always_comb begin
      o_req_ready = (state_q == S_IDLE);
      o_rsp_valid = (state_q == S_RESP);
      o_rsp_data  = rdata_q;
      o_rsp_err   = err_q;
      o_err_cnt   = ecnt_q;
      o_tgt_sel   = '0;
      o_tgt_addr  = '0;
      o_tgt_data  = '0;
      o_tgt_wren  = 1'b0;
      o_tgt_mask  = '0;
      if (state_q == S_REQ) begin
         o_tgt_sel[tgt_q] = 1'b1;
         o_tgt_addr       = off_q;
         o_tgt_data       = wdata_q;
         o_tgt_wren       = wren_q;
         o_tgt_mask       = mask_q;
      end
   end

endmodule

// File: tb/tb_mem_xbar_n.sv
// Directed bench for mem_xbar_n: two targets, an 8-cycle watchdog, and a
// transaction-level model of routing, responses and the error counter.
module tb_mem_xbar_n;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [29:0] i_addr = '0;
   logic [31:0] i_data = '0;
   logic        i_wren = 1'b0;
   logic [3:0]  i_mask = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_data;
   logic        o_rsp_err;
   logic [15:0] o_err_cnt;
   logic [1:0]  o_tgt_sel;
   logic [29:0] o_tgt_addr;
   logic [31:0] o_tgt_data;
   logic        o_tgt_wren;
   logic [3:0]  o_tgt_mask;
   logic [1:0]  i_tgt_ready = '0;
   logic [1:0]  i_tgt_rsp_valid = '0;
   logic [63:0] i_tgt_rsp_data = '0;

   mem_xbar_n #(
      .NUM_TGT(2), .AW(30), .DW(32),
      .TGT_BASE({30'h1000, 30'h0000}),
      .TGT_LIMIT({30'h1100, 30'h1000}),
      .TIMEOUT(TMO), .ECW(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_addr(i_addr), .i_data(i_data), .i_wren(i_wren), .i_mask(i_mask),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_err_cnt(o_err_cnt),
      .o_tgt_sel(o_tgt_sel), .o_tgt_addr(o_tgt_addr), .o_tgt_data(o_tgt_data),
      .o_tgt_wren(o_tgt_wren), .o_tgt_mask(o_tgt_mask),
      .i_tgt_ready(i_tgt_ready), .i_tgt_rsp_valid(i_tgt_rsp_valid),
      .i_tgt_rsp_data(i_tgt_rsp_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Transaction-level model: region table plus the expected in-flight request/response.
   logic [29:0] m_base [0:1];
   logic [29:0] m_lim  [0:1];
   logic [1:0]  mdl_sel = '0;
   logic [29:0] mdl_off = '0;
   logic [31:0] mdl_wd = '0;
   logic        mdl_wr = 1'b0;
   logic [3:0]  mdl_mk = '0;
   logic [31:0] mdl_rdata = '0;
   logic        mdl_err = 1'b0;
   int          mdl_ecnt = 0;
   logic        mdl_pending = 1'b0;

   logic [1:0]  cap_sel;
   logic [29:0] cap_addr;
   logic [31:0] cap_wd, cap_rdata;
   logic        cap_wren, cap_err;
   logic [3:0]  cap_mask;
   logic [15:0] cap_ecnt;
   int          cap_c;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int mdl_decode(input logic [29:0] a);
      for (int k = 0; k < 2; k++)
         if (a >= m_base[k] && a < m_lim[k]) return k;
      return -1;
   endfunction

   // Selected target follows the scenario; the other one asserts ready/valid constantly.
   task automatic drive_tgt(input int k, input int c, input int rdy_d, input int cpl,
                            input logic [31:0] rd);
      logic [1:0]  tr, tv;
      logic [63:0] td;
      tr = 2'b11;
      tv = 2'b11;
      td = {2{32'hBAD0_BAD0}};
      if (k >= 0) begin
         tr[k] = (c >= rdy_d);
         tv[k] = (c == cpl);
         td[k*32 +: 32] = (c == cpl) ? rd : (32'hCCCC_0000 + 32'(c));
      end
      i_tgt_ready     = tr;
      i_tgt_rsp_valid = tv;
      i_tgt_rsp_data  = td;
   endtask

   task automatic do_txn(input string nm, input logic [29:0] a, input logic wr,
                         input logic [31:0] wd, input logic [3:0] mk, input int rdy_d,
                         input int rsp_d, input logic [31:0] rd, input int bp);
      int   k, cpl, exp_c;
      logic to;
      k     = mdl_decode(a);
      cpl   = (rsp_d < 0) ? 1000 : rdy_d + rsp_d;
      to    = (k >= 0) && (cpl >= TMO);
      exp_c = (k < 0) ? 0 : (to ? TMO : cpl + 1);
      @(negedge clk);
      chk({nm, "_idle_ready"}, o_req_ready, 1'b1);
      @(posedge clk); #1;
      i_req_valid = 1'b1; i_addr = a; i_data = wd; i_wren = wr; i_mask = mk;
      @(posedge clk); #1;
      i_req_valid = 1'b0; i_addr = '0; i_data = '0; i_wren = 1'b0; i_mask = '0;
      mdl_sel   = (k >= 0) ? 2'(1 << k) : 2'b00;
      mdl_off   = (k >= 0) ? a - m_base[k] : 30'h0;
      mdl_wd    = wd;
      mdl_wr    = wr;
      mdl_mk    = mk;
      mdl_rdata = (k >= 0 && !to && !wr) ? rd : 32'h0;
      mdl_err   = (k < 0) || to;
      if (mdl_err) mdl_ecnt++;
      mdl_pending = 1'b1;
      cap_c = -1;
      for (int c = 0; c < 40; c++) begin
         drive_tgt(k, c, rdy_d, cpl, rd);
         @(negedge clk);
         if (c == 0) begin
            cap_sel = o_tgt_sel; cap_addr = o_tgt_addr; cap_wd = o_tgt_data;
            cap_wren = o_tgt_wren; cap_mask = o_tgt_mask;
         end
         chk({nm, "_sel_window"}, o_tgt_sel != 2'b00, (k >= 0) && (c <= rdy_d) && (c < TMO));
         if (o_rsp_valid) begin
            cap_c = c; cap_rdata = o_rsp_data; cap_err = o_rsp_err; cap_ecnt = o_err_cnt;
            break;
         end
         @(posedge clk); #1;
      end
      chk({nm, "_latency"}, cap_c, exp_c);
      for (int b = 0; b < bp; b++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk({nm, "_bp_valid"}, o_rsp_valid, 1'b1);
         chk({nm, "_bp_ready"}, o_req_ready, 1'b0);
      end
      @(posedge clk); #1;
      i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      i_rsp_ready = 1'b0;
      mdl_pending = 1'b0;
      i_tgt_ready = '0; i_tgt_rsp_valid = '0; i_tgt_rsp_data = '0;
      @(negedge clk);
      chk({nm, "_post_ready"}, o_req_ready, 1'b1);
      chk({nm, "_post_valid"}, o_rsp_valid, 1'b0);
   endtask

   // Per-cycle comparison of the shared bus and the response against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_tgt_sel != 2'b00) begin
            chk("bus_sel",  o_tgt_sel,  mdl_sel);
            chk("bus_addr", o_tgt_addr, mdl_off);
            chk("bus_data", o_tgt_data, mdl_wd);
            chk("bus_wren", o_tgt_wren, mdl_wr);
            chk("bus_mask", o_tgt_mask, mdl_mk);
            chk("bus_rdy",  o_req_ready, 1'b0);
         end else begin
            chk("bus_idle", {o_tgt_addr, o_tgt_data, o_tgt_wren, o_tgt_mask}, 67'h0);
         end
         if (o_rsp_valid) begin
            if (!mdl_pending) begin
               chk("rsp_spurious", o_rsp_valid, 1'b0);
            end else begin
               chk("rsp_data", o_rsp_data, mdl_rdata);
               chk("rsp_err",  o_rsp_err,  mdl_err);
               chk("rsp_ecnt", o_err_cnt,  16'(mdl_ecnt));
               chk("rsp_rdy",  o_req_ready, 1'b0);
            end
         end
      end
   end

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_req_ready"}, o_req_ready, 1'b1);
      chk({nm, "_rsp_valid"}, o_rsp_valid, 1'b0);
      chk({nm, "_rsp_data"},  o_rsp_data, 32'h0);
      chk({nm, "_rsp_err"},   o_rsp_err, 1'b0);
      chk({nm, "_err_cnt"},   o_err_cnt, 16'h0);
      chk({nm, "_tgt"}, {o_tgt_sel, o_tgt_addr, o_tgt_data, o_tgt_wren, o_tgt_mask}, 69'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got stuck, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      m_base[0] = 30'h0000; m_lim[0] = 30'h1000;
      m_base[1] = 30'h1000; m_lim[1] = 30'h1100;

      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Route to target 1, zero-wait read.
      do_txn("route", 30'h1004, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0);
      chk("route_sel",  cap_sel, 2'b10);
      chk("route_off",  cap_addr, 30'h4);
      chk("route_lat",  cap_c, 1);
      chk("route_data", cap_rdata, 32'hDEAD_BEEF);
      chk("route_err",  cap_err, 1'b0);

      // Decode miss.
      do_txn("miss", 30'h2000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 0);
      chk("miss_lat",  cap_c, 0);
      chk("miss_sel",  cap_sel, 2'b00);
      chk("miss_err",  cap_err, 1'b1);
      chk("miss_data", cap_rdata, 32'h0);
      chk("miss_ecnt", cap_ecnt, 16'd1);

      // Wait states on target 0 with response back-pressure.
      do_txn("wait", 30'h0123, 1'b0, 32'h0, 4'hF, 3, 2, 32'hA5A5_5A5A, 4);
      chk("wait_lat",  cap_c, 6);
      chk("wait_data", cap_rdata, 32'hA5A5_5A5A);

      // Write at the top word of target 0.
      do_txn("write", 30'h0FFF, 1'b1, 32'h1234_5678, 4'b0011, 0, 1, 32'hFFFF_0000, 1);
      chk("write_sel",  cap_sel, 2'b01);
      chk("write_off",  cap_addr, 30'hFFF);
      chk("write_wd",   cap_wd, 32'h1234_5678);
      chk("write_wren", cap_wren, 1'b1);
      chk("write_mask", cap_mask, 4'b0011);
      chk("write_data", cap_rdata, 32'h0);
      chk("write_err",  cap_err, 1'b0);

      // Region boundaries: base is inclusive, limit is exclusive.
      do_txn("base", 30'h1000, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0BAD_F00D, 0);
      chk("base_off", cap_addr, 30'h0);
      do_txn("limit", 30'h1100, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 0);
      chk("limit_err", cap_err, 1'b1);
      chk("limit_ecnt", cap_ecnt, 16'd2);

      // Watchdog: never responds, completes on the last allowed cycle, one cycle too late.
      do_txn("tmo", 30'h1050, 1'b0, 32'h0, 4'hF, 2, -1, 32'h0, 0);
      chk("tmo_lat",  cap_c, 8);
      chk("tmo_err",  cap_err, 1'b1);
      chk("tmo_ecnt", cap_ecnt, 16'd3);
      do_txn("edge_ok", 30'h0010, 1'b0, 32'h0, 4'hF, 7, 0, 32'h7777_0007, 0);
      chk("edge_ok_err",  cap_err, 1'b0);
      chk("edge_ok_data", cap_rdata, 32'h7777_0007);
      do_txn("edge_late", 30'h0011, 1'b0, 32'h0, 4'hF, 4, 4, 32'h8888_0008, 0);
      chk("edge_late_err",  cap_err, 1'b1);
      chk("edge_late_ecnt", cap_ecnt, 16'd4);

      // Late target responses while idle change nothing.
      @(posedge clk); #1;
      i_tgt_ready = 2'b11; i_tgt_rsp_valid = 2'b11; i_tgt_rsp_data = {2{32'h1A7E_1A7E}};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("late_valid", o_rsp_valid, 1'b0);
         chk("late_ready", o_req_ready, 1'b1);
         chk("late_ecnt",  o_err_cnt, 16'd4);
         @(posedge clk); #1;
      end
      i_tgt_ready = '0; i_tgt_rsp_valid = '0; i_tgt_rsp_data = '0;

      // Reset while waiting on target 0.
      @(posedge clk); #1;
      i_req_valid = 1'b1; i_addr = 30'h0200; i_data = 32'h0; i_wren = 1'b0; i_mask = 4'hF;
      @(posedge clk); #1;
      i_req_valid = 1'b0; i_addr = '0; i_mask = '0;
      mdl_sel = 2'b01; mdl_off = 30'h200; mdl_wd = 32'h0; mdl_wr = 1'b0; mdl_mk = 4'hF;
      i_tgt_ready = 2'b11; i_tgt_rsp_valid = 2'b10;
      @(negedge clk);
      chk("rstw_req_sel", o_tgt_sel, 2'b01);
      @(posedge clk); #1;
      i_tgt_ready = 2'b10;
      @(negedge clk);
      chk("rstw_wait_sel", o_tgt_sel, 2'b00);
      chk("rstw_wait_valid", o_rsp_valid, 1'b0);
      chk("rstw_wait_ready", o_req_ready, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rstw");
      mdl_ecnt = 0;
      mdl_pending = 1'b0;
      @(posedge clk); #1;
      i_tgt_ready = '0; i_tgt_rsp_valid = '0;
      rst_n = 1'b1;

      do_txn("after_rst", 30'h1010, 1'b0, 32'h0, 4'hF, 0, 1, 32'hC0FF_EE00, 0);
      chk("after_rst_data", cap_rdata, 32'hC0FF_EE00);
      chk("after_rst_ecnt", cap_ecnt, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_xbar_n.md
# mem_xbar_n

Parametrised N-target memory crossbar with a valid/ready request handshake, registered target-select, variable-latency target responses, a timeout watchdog and error reporting. It sits between the CPU load/store unit and the data-side targets (DMEM, MMIO, further peripherals). It translates word addresses into per-target offsets and returns exactly one response per accepted request. One transaction is outstanding at a time.

## Interface
Parameters:
- NUM_TGT, 2, number of targets (1..8)
- AW, 30, word-address width
- DW, 32, data width; mask width is DW/8
- TGT_BASE, packed NUM_TGT*AW, per-target inclusive base word address; target k occupies bits [k*AW +: AW]
- TGT_LIMIT, packed NUM_TGT*AW, per-target exclusive limit word address
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before an error response; 0 disables the watchdog
- ECW, 16, error-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  initiator request valid
- o_req_ready  out  1  crossbar can accept a request
- i_addr  in  AW  word address
- i_data  in  DW  write data
- i_wren  in  1  1 = write, 0 = read
- i_mask  in  DW/8  byte-enable
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  initiator accepts the response
- o_rsp_data  out  DW  read data (0 for writes and errors)
- o_rsp_err  out  1  decode error or timeout
- o_err_cnt  out  ECW  saturating error count
- o_tgt_sel  out  NUM_TGT  one-hot target request strobe
- o_tgt_addr  out  AW  offset (addr − TGT_BASE[k]), shared by all targets
- o_tgt_data  out  DW  shared write data
- o_tgt_wren  out  1  shared write enable
- o_tgt_mask  out  DW/8  shared byte-enable
- i_tgt_ready  in  NUM_TGT  target k accepts the strobe
- i_tgt_rsp_valid  in  NUM_TGT  target k completion (read data valid / write ack)
- i_tgt_rsp_data  in  NUM_TGT*DW  target k read data at [k*DW +: DW]

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- o_req_ready = (state == IDLE).
- IDLE:
  - On i_req_valid & o_req_ready, latch addr, data, wren and mask.
  - Decode: target k hits when TGT_BASE[k] <= addr < TGT_LIMIT[k]. The lowest matching index wins.
  - On a hit, latch k and the offset, then go to REQ.
  - On a miss, go to RESP with err=1 and data=0.
- REQ:
  - Drive o_tgt_sel[k]=1 and the shared bus from the latched values.
  - i_tgt_ready[k] & i_tgt_rsp_valid[k] together → RESP.
  - i_tgt_ready[k] alone → WAIT.
- WAIT:
  - o_tgt_sel=0.
  - On i_tgt_rsp_valid[k], capture data (only when wren=0, otherwise 0), set err=0 and go to RESP.
- RESP:
  - Hold o_rsp_valid=1 with stable data and err until i_rsp_ready, then go to IDLE.
- Watchdog:
  - The counter clears when REQ is entered and increments each cycle in REQ or WAIT.
  - On count == TIMEOUT−1 without completion: go to RESP with err=1, data=0, and drop o_tgt_sel.
  - Completion takes priority over timeout in the same cycle.
- Responses and readies from non-selected targets are ignored in all states. A late response from a timed-out target is ignored.
- o_err_cnt increments by 1 on each entry to RESP with err=1, and saturates at all-ones.
- Outside REQ, o_tgt_sel=0 and o_tgt_addr, o_tgt_data, o_tgt_wren and o_tgt_mask are 0. No X is driven.
- Offset subtraction is AW bits wide. It never underflows because of the decode condition.
- Overlapping regions are legal; the lowest index takes priority. A region with base >= limit never hits.

## Timing
- Reset values: o_req_ready=1, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_err_cnt=0, o_tgt_sel=0, all shared target outputs 0.
- Reset asserted mid-transaction aborts immediately. No response is produced for it.
- Accept at edge N → o_tgt_sel high in cycle N+1 (registered).
- Zero-wait target (ready and rsp in N+1) → o_rsp_valid in cycle N+2. Minimum hit latency is 2 cycles.
- Decode miss → o_rsp_valid in cycle N+1.
- Response handshake at edge M → o_req_ready=1 in cycle M+1. Back-to-back throughput is one transaction per 3 cycles minimum.
- Timeout: o_rsp_valid rises TIMEOUT cycles after REQ entry.
- o_rsp_* are registered outputs. o_req_ready and o_tgt_* are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- Decode routing, with NUM_TGT=2, BASE={0x1000, 0x0}, LIMIT={0x1100, 0x1000}:
  - Read 0x1004 → o_tgt_sel=2'b10, o_tgt_addr=0x4.
  - The target returns 0xDEADBEEF the same cycle → o_rsp_valid 2 cycles after accept, data 0xDEADBEEF, err 0.
- Decode miss: request to 0x2000 → o_rsp_valid next cycle, err=1, data=0, o_tgt_sel stays 0, o_err_cnt=1.
- Wait states and back-pressure:
  - Target 0 holds ready low 3 cycles, then ready, then rsp 2 cycles later.
  - Hold i_rsp_ready low 4 cycles → response stays stable.
  - o_req_ready returns 1 only after the handshake.
- Write: wren=1, mask=4'b0011, data 0x12345678 → the shared bus carries these values while sel is high. The response returns data=0, err=0 on ack.
- Timeout, with TIMEOUT=8 and a target that never responds:
  - err response 8 cycles after REQ entry, o_err_cnt increments.
  - A late i_tgt_rsp_valid in IDLE has no effect.
- Reset during WAIT: drop rst_n → all outputs return to reset values asynchronously. After release, a new request completes normally.
